// File: rtl/tick_sched.sv
// Programmable-rate tick scheduler with pause, manual rate requests
// and automatic speed-up after a fixed number of ticks.
module tick_sched #(
   parameter int unsigned PER0 = 1000000,
   parameter int unsigned PER1 = 1250000,
   parameter int unsigned PER2 = 1500000,
   parameter int unsigned PER3 = 1750000,
   parameter int unsigned TPL  = 16
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       pause,
   input  logic       auto_en,
   input  logic [1:0] rate_req,
   input  logic       rate_req_valid,
   output logic       tick,
   output logic       rate_ack,
   output logic [1:0] rate_sel,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2
   } st_t;

   localparam logic [7:0] TPL8 = 8'(TPL);

   st_t         st_q, st_d;
   logic [24:0] cnt_q, cnt_d;
   logic        tick_d, ack_d;
   logic [1:0]  rate_d, nr;
   logic        pv_q, pv_d;
   logic [1:0]  pr_q, pr_d;
   logic [7:0]  tc_q, tc_d;

   function automatic logic [24:0] reload(input logic [1:0] r);
      case (r)
         2'd0:    reload = 25'(PER0 - 1);
         2'd1:    reload = 25'(PER1 - 1);
         2'd2:    reload = 25'(PER2 - 1);
         default: reload = 25'(PER3 - 1);
      endcase
   endfunction

   always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      ack_d  = 1'b0;
      rate_d = rate_sel;
      nr     = rate_sel;
      pv_d   = pv_q;
      pr_d   = pr_q;
      tc_d   = tc_q;
      if (stop) begin
         st_d  = IDLE;
         cnt_d = '0;
         pv_d  = 1'b0;
         tc_d  = '0;
      end else begin
         unique case (st_q)
            IDLE: begin
               cnt_d = '0;
               if (pv_q) begin
                  nr     = pr_q;
                  rate_d = pr_q;
                  ack_d  = 1'b1;
                  pv_d   = 1'b0;
               end
               if (start) begin
                  st_d  = RUN;
                  cnt_d = reload(nr);
                  tc_d  = '0;
               end
            end
            RUN: begin
               if (cnt_q == '0) begin
                  tick_d = 1'b1;
                  if (pv_q) begin
                     nr    = pr_q;
                     ack_d = 1'b1;
                     pv_d  = 1'b0;
                     tc_d  = '0;
                  end else if (auto_en) begin
                     // auto step: speed up one rate, saturating at 0
                     if (tc_q + 8'd1 == TPL8) begin
                        tc_d = '0;
                        nr   = (rate_sel == 2'd0) ? 2'd0 : rate_sel - 2'd1;
                     end else begin
                        tc_d = tc_q + 8'd1;
                     end
                  end
                  rate_d = nr;
                  cnt_d  = reload(nr);
               end else if (!pause) begin
                  cnt_d = cnt_q - 25'd1;
               end
               if (pause) st_d = PAUSED;
            end
            PAUSED: begin
               if (!pause) begin
                  st_d  = RUN;
                  cnt_d = cnt_q - 25'd1;
               end
            end
            default: st_d = IDLE;
         endcase
         if (!auto_en) tc_d = '0;
         // a strobe on an apply edge stays pending for the next one
         if (rate_req_valid) begin
            pv_d = 1'b1;
            pr_d = rate_req;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         st_q     <= IDLE;
         cnt_q    <= '0;
         tick     <= 1'b0;
         rate_ack <= 1'b0;
         rate_sel <= 2'd0;
         pv_q     <= 1'b0;
         pr_q     <= 2'd0;
         tc_q     <= '0;
      end else begin
         st_q     <= st_d;
         cnt_q    <= cnt_d;
         tick     <= tick_d;
         rate_ack <= ack_d;
         rate_sel <= rate_d;
         pv_q     <= pv_d;
         pr_q     <= pr_d;
         tc_q     <= tc_d;
      end
   end

   assign state = st_q;

endmodule

// File: tb/tb_tick_sched.sv
// Randomized and directed bench for tick_sched against an
// elapsed-cycle reference model.
module tb_tick_sched;

   localparam int TPL = 3;

   logic       clk_in = 1'b0;
   logic       reset, start, stop, pause, auto_en;
   logic [1:0] rate_req;
   logic       rate_req_valid;
   logic       tick, rate_ack;
   logic [1:0] rate_sel, state;

   int checks = 0;
   int errors = 0;

   int per [4] = '{4, 5, 6, 7};
   int m_st, m_el, m_rate, m_pv, m_pr, m_tc, m_tick, m_ack;

   tick_sched #(
      .PER0(4), .PER1(5), .PER2(6), .PER3(7), .TPL(TPL)
   ) dut (
      .clk_in(clk_in),
      .reset(reset),
      .start(start),
      .stop(stop),
      .pause(pause),
      .auto_en(auto_en),
      .rate_req(rate_req),
      .rate_req_valid(rate_req_valid),
      .tick(tick),
      .rate_ack(rate_ack),
      .rate_sel(rate_sel),
      .state(state)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // m_el counts cycles elapsed in the current period
   task automatic model_step();
      m_tick = 0;
      m_ack  = 0;
      if (reset) begin
         m_st = 0; m_el = 0; m_rate = 0;
         m_pv = 0; m_pr = 0; m_tc = 0;
      end else if (stop) begin
         m_st = 0; m_el = 0; m_pv = 0; m_tc = 0;
      end else begin
         case (m_st)
            0: begin
               if (m_pv != 0) begin
                  m_rate = m_pr; m_ack = 1; m_pv = 0;
               end
               if (start) begin
                  m_st = 1; m_el = 0; m_tc = 0;
               end
            end
            1: begin
               if (m_el == per[m_rate] - 1) begin
                  m_tick = 1;
                  m_el   = 0;
                  if (m_pv != 0) begin
                     m_rate = m_pr; m_ack = 1; m_pv = 0; m_tc = 0;
                  end else if (auto_en) begin
                     m_tc++;
                     if (m_tc == TPL) begin
                        m_tc = 0;
                        if (m_rate > 0) m_rate--;
                     end
                  end
               end else if (!pause) begin
                  m_el++;
               end
               if (pause) m_st = 2;
            end
            default: begin
               if (!pause) begin
                  m_st = 1; m_el++;
               end
            end
         endcase
         if (!auto_en) m_tc = 0;
         if (rate_req_valid) begin
            m_pv = 1; m_pr = int'(rate_req);
         end
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      model_step();
      #1;
      chk("tick", int'(tick), m_tick);
      chk("rate_ack", int'(rate_ack), m_ack);
      chk("rate_sel", int'(rate_sel), m_rate);
      chk("state", int'(state), m_st);
      rate_req_valid = 1'b0;
      reset = 1'b0;
   endtask

   task automatic wait_tick(input int budget, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!tick && n < budget);
      if (!tick) chk("tick_timeout", 0, 1);
   endtask

   task automatic strobe(input int r);
      rate_req = 2'(r);
      rate_req_valid = 1'b1;
   endtask

   int n, acks, tks;
   int tq[$];

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
      auto_en = 1'b0; rate_req = 2'd0; rate_req_valid = 1'b0;
      step();
      chk("rst_state", int'(state), 0);
      chk("rst_sel", int'(rate_sel), 0);

      // basic periodic ticks at rate 0
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (tick) tq.push_back(k);
      end
      chk("ntick", tq.size(), 3);
      chk("tick_a", tq[0], 4);
      chk("tick_b", tq[1], 8);
      chk("tick_c", tq[2], 12);

      // mid-period request for rate 3
      step();
      strobe(3);
      step();
      chk("sel_hold", int'(rate_sel), 0);
      wait_tick(20, n);
      chk("ack_w_tick", int'(rate_ack), 1);
      chk("sel3", int'(rate_sel), 3);
      wait_tick(20, n);
      chk("per3", n, 7);

      // last strobe wins, single ack
      strobe(1);
      step();
      step();
      strobe(2);
      step();
      acks = 0;
      n = 0;
      do begin
         step();
         n++;
         acks += int'(rate_ack);
      end while (!tick && n < 20);
      chk("one_ack", acks, 1);
      chk("sel2", int'(rate_sel), 2);
      wait_tick(20, n);
      chk("per2", n, 6);

      // pause with counter at 2
      step(); step(); step();
      pause = 1'b1;
      tks = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         tks += int'(tick);
      end
      chk("pause_noticks", tks, 0);
      chk("paused_state", int'(state), 2);
      pause = 1'b0;
      wait_tick(20, n);
      chk("resume_gap", n, 3);

      // auto speed-up from rate 3
      stop = 1'b1;
      step();
      stop = 1'b0;
      strobe(3);
      step();
      step();
      auto_en = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      acks = 0;
      for (int t = 1; t <= 12; t++) begin
         n = 0;
         do begin
            step();
            n++;
            acks += int'(rate_ack);
         end while (!tick && n < 20);
         if (t == 3) chk("auto_r2", int'(rate_sel), 2);
         if (t == 4) chk("auto_p6", n, 6);
         if (t == 6) chk("auto_r1", int'(rate_sel), 1);
         if (t == 9) chk("auto_r0", int'(rate_sel), 0);
         if (t == 12) chk("auto_sat", int'(rate_sel), 0);
      end
      chk("auto_noack", acks, 0);
      auto_en = 1'b0;

      // stop with start in RUN, then reset on a boundary
      strobe(2);
      step();
      stop = 1'b1;
      start = 1'b1;
      step();
      stop = 1'b0;
      start = 1'b0;
      chk("stop_idle", int'(state), 0);
      step();
      chk("stop_noack", int'(rate_ack), 0);
      start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (m_el != per[m_rate] - 1 && n < 20) begin
         step();
         n++;
      end
      reset = 1'b1;
      step();
      chk("rst_notick", int'(tick), 0);
      chk("rst_sel0", int'(rate_sel), 0);

      // randomized traffic
      for (int k = 0; k < 4000; k++) begin
         reset = ($urandom_range(0, 299) == 0);
         stop = ($urandom_range(0, 59) == 0);
         start = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 5) == 0) pause = ~pause;
         if ($urandom_range(0, 99) == 0) auto_en = ~auto_en;
         rate_req = 2'($urandom_range(0, 3));
         rate_req_valid = ($urandom_range(0, 11) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
